// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared definitions for the Debug Module DMI responder.
//               Includes DMI op encodings, register addresses, cmderr codes,
//               abstract command field positions and the command FSM state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

  // DMI operation encodings. Any other value is a nop.
  localparam logic [1:0] DMI_OP_READ  = 2'b01;
  localparam logic [1:0] DMI_OP_WRITE = 2'b10;

  // Debug Module register addresses
  localparam logic [6:0] ADDR_DATA0        = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL    = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS     = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS   = 7'h16;
  localparam logic [6:0] ADDR_COMMAND      = 7'h17;
  localparam logic [6:0] ADDR_ABSTRACTAUTO = 7'h18;

  // abstractcs.cmderr codes
  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

  // Access Register command field positions
  localparam int CMD_TYPE_LSB     = 24;  // cmdtype [31:24]
  localparam int CMD_AARSIZE_LSB  = 20;  // aarsize [22:20]
  localparam int CMD_POSTEXEC_BIT = 18;
  localparam int CMD_TRANSFER_BIT = 17;
  localparam int CMD_WRITE_BIT    = 16;

  localparam logic [2:0]  AARSIZE_32     = 3'd2;
  localparam logic [15:0] REGNO_GPR_BASE = 16'h1000;

  // Abstract command FSM states
  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_REQ  = 2'd1,
    C_DONE = 2'd2
  } cmd_state_e;

endpackage
`default_nettype wire

// File: rtl/dm_abstract_cmd.sv
`default_nettype none
// ============================================================================
// Module      : dm_abstract_cmd
// Description : Abstract command FSM with the GPR access handshake
//               (ar_*). The FSM validates an issued command word. It
//               reports cmderr codes and drives one register access
//               until ar_ready.
// Revision    : 1.0 - initial release
// Ports       :
//   clk, rst       clock, synchronous active-high reset
//   start          issue cmd (only acted on in C_IDLE)
//   cmd            32-bit command word
//   wdata          data0 value to send with a GPR write
//   hart_halted    hart halt status
//   busy           command in progress (C_REQ or C_DONE)
//   err_set        pulse, cmderr must be loaded with err_code
//   err_code       cmderr value to load
//   rdata_valid    pulse, ar_rdata carries a completed GPR read
//   ar_*           abstract register access handshake
// ============================================================================
module dm_abstract_cmd #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cmd,
  input  logic [31:0] wdata,
  input  logic        hart_halted,
  output logic        busy,
  output logic        err_set,
  output logic [2:0]  err_code,
  output logic        rdata_valid,
  output logic        ar_valid,
  output logic        ar_write,
  output logic [4:0]  ar_regno,
  output logic [31:0] ar_wdata,
  input  logic        ar_ready
);
  import dm_pkg::*;

  localparam logic [16:0] GPR_END = 17'(REGNO_GPR_BASE) + 17'(NREGS);

  cmd_state_e state, state_nxt;
  logic       latch;
  logic       transfer;
  logic       in_range;
  logic       unsupported;

  // aarpostincrement and bit 23 do not affect this implementation.
  logic unused_cmd_bits;
  assign unused_cmd_bits = &{1'b0, cmd[23], cmd[19]};

  assign transfer = cmd[CMD_TRANSFER_BIT];
  assign in_range = (cmd[15:0] >= REGNO_GPR_BASE) && ({1'b0, cmd[15:0]} < GPR_END);
  assign unsupported = (cmd[CMD_TYPE_LSB +: 8] != 8'd0)
                    || (cmd[CMD_AARSIZE_LSB +: 3] != AARSIZE_32)
                    || cmd[CMD_POSTEXEC_BIT]
                    || (transfer && !in_range);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= C_IDLE;
      ar_write <= 1'b0;
      ar_regno <= 5'd0;
      ar_wdata <= 32'd0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        ar_write <= cmd[CMD_WRITE_BIT];
        ar_regno <= cmd[4:0];
        ar_wdata <= wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    err_set   = 1'b0;
    err_code  = CMDERR_NONE;
    ar_valid  = 1'b0;
    busy      = (state != C_IDLE);
    case (state)
      C_IDLE: begin
        if (start) begin
          if (unsupported) begin
            err_set  = 1'b1;
            err_code = CMDERR_NOTSUP;
          end else if (transfer && !hart_halted) begin
            err_set  = 1'b1;
            err_code = CMDERR_HALTRESUME;
          end else if (transfer) begin
            latch     = 1'b1;
            state_nxt = C_REQ;
          end
          // transfer=0: completes immediately without any action
        end
      end
      C_REQ: begin
        ar_valid = 1'b1;
        if (ar_ready) state_nxt = C_DONE;
      end
      C_DONE:  state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  assign rdata_valid = ar_valid && ar_ready && !ar_write;

endmodule
`default_nettype wire

// File: rtl/dm_dmi_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_dmi_responder
// Description : Debug Module register file and DMI decode (responder side).
//               Includes data0, dmcontrol, dmstatus, abstractcs and command.
//               Controls halt/resume for one hart and issues abstract GPR
//               commands through dm_abstract_cmd.
//               Optional macro DM_AUTOEXEC_EN adds abstractauto (0x18) with
//               autoexecdata.
// Revision    : 1.0 - initial release
// Ports       :
//   clk, rst              clock, synchronous active-high reset
//   dmi_req_*             request (valid strobe, addr, data, op)
//   dmi_rsp_valid/data    response, exactly one cycle after the request
//   hart_halt_req         level, dmcontrol.haltreq
//   hart_resume_req       one-cycle resume pulse
//   hart_halted           hart status input
//   hart_resume_ack       one-cycle pulse from hart
//   ndmreset              dmcontrol.ndmreset
//   ar_*                  abstract GPR access handshake
// ============================================================================
module dm_dmi_responder #(
  parameter int DM_VERSION = 2,
  parameter int NREGS      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmi_req_valid,
  input  logic [6:0]  dmi_req_addr,
  input  logic [31:0] dmi_req_data,
  input  logic [1:0]  dmi_req_op,
  output logic        dmi_rsp_valid,
  output logic [31:0] dmi_rsp_data,
  output logic        hart_halt_req,
  output logic        hart_resume_req,
  input  logic        hart_halted,
  input  logic        hart_resume_ack,
  output logic        ndmreset,
  output logic        ar_valid,
  output logic        ar_write,
  output logic [4:0]  ar_regno,
  output logic [31:0] ar_wdata,
  input  logic [31:0] ar_rdata,
  input  logic        ar_ready
);
  import dm_pkg::*;

  logic [31:0] data0;
  logic        dmactive;
  logic [2:0]  cmderr;
  logic        resumeack;

  logic        is_rd, is_wr;
  logic        wr_data0, wr_dmcontrol, wr_abstractcs, wr_command;
  logic        busy, busy_viol;
  logic        dmactive_nxt;
  logic        auto_trig;
  logic        cmd_start;
  logic [31:0] cmd_word;
  logic [31:0] cmd_wdata;
  logic        err_set;
  logic [2:0]  err_code;
  logic        rdata_valid;
  logic [31:0] rd_val;

  assign is_rd         = dmi_req_valid && (dmi_req_op == DMI_OP_READ);
  assign is_wr         = dmi_req_valid && (dmi_req_op == DMI_OP_WRITE);
  assign wr_data0      = is_wr && (dmi_req_addr == ADDR_DATA0);
  assign wr_dmcontrol  = is_wr && (dmi_req_addr == ADDR_DMCONTROL);
  assign wr_abstractcs = is_wr && (dmi_req_addr == ADDR_ABSTRACTCS);
  assign wr_command    = is_wr && (dmi_req_addr == ADDR_COMMAND);
  assign busy_viol     = busy && (wr_data0 || wr_abstractcs || wr_command);
  assign dmactive_nxt  = wr_dmcontrol ? dmi_req_data[0] : dmactive;

`ifdef DM_AUTOEXEC_EN
  logic        autoexec;
  logic [31:0] last_cmd;

  assign auto_trig = dmactive && autoexec && !busy && (cmderr == CMDERR_NONE)
                  && (is_rd || is_wr) && (dmi_req_addr == ADDR_DATA0);
  assign cmd_word  = wr_command ? dmi_req_data : last_cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      autoexec <= 1'b0;
      last_cmd <= 32'd0;
    end else begin
      if (wr_command && cmd_start) last_cmd <= dmi_req_data;
      if (is_wr && (dmi_req_addr == ADDR_ABSTRACTAUTO)) autoexec <= dmi_req_data[0];
      if (!dmactive_nxt) autoexec <= 1'b0;
    end
  end
`else
  assign auto_trig = 1'b0;
  assign cmd_word  = dmi_req_data;
`endif

  // A command is only considered when the DM is active, idle and error-free.
  assign cmd_start = dmactive && !busy && (cmderr == CMDERR_NONE) && (wr_command || auto_trig);
  // An autoexec-triggered data0 write sends the value just written.
  assign cmd_wdata = wr_data0 ? dmi_req_data : data0;

  dm_abstract_cmd #(
    .NREGS (NREGS)
  ) u_abstract_cmd (
    .clk         (clk),
    .rst         (rst),
    .start       (cmd_start),
    .cmd         (cmd_word),
    .wdata       (cmd_wdata),
    .hart_halted (hart_halted),
    .busy        (busy),
    .err_set     (err_set),
    .err_code    (err_code),
    .rdata_valid (rdata_valid),
    .ar_valid    (ar_valid),
    .ar_write    (ar_write),
    .ar_regno    (ar_regno),
    .ar_wdata    (ar_wdata),
    .ar_ready    (ar_ready)
  );

  always_comb begin
    rd_val = 32'd0;
    case (dmi_req_addr)
      ADDR_DATA0:      rd_val = data0;
      ADDR_DMCONTROL:  rd_val = {hart_halt_req, 29'd0, ndmreset, dmactive};
      ADDR_DMSTATUS:   rd_val = {14'd0, resumeack, resumeack, 4'd0,
                                 ~hart_halted, ~hart_halted, hart_halted, hart_halted,
                                 1'b1, 3'd0, 4'(DM_VERSION)};
      ADDR_ABSTRACTCS: rd_val = {3'd0, 5'd0, 11'd0, busy, 1'b0, cmderr, 4'd0, 4'd1};
`ifdef DM_AUTOEXEC_EN
      ADDR_ABSTRACTAUTO: rd_val = {31'd0, autoexec};
`endif
      default:         rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmi_rsp_valid   <= 1'b0;
      dmi_rsp_data    <= 32'd0;
      data0           <= 32'd0;
      dmactive        <= 1'b0;
      hart_halt_req   <= 1'b0;
      ndmreset        <= 1'b0;
      hart_resume_req <= 1'b0;
      cmderr          <= CMDERR_NONE;
      resumeack       <= 1'b0;
    end else begin
      dmi_rsp_valid   <= dmi_req_valid;
      dmi_rsp_data    <= is_rd ? rd_val : 32'd0;
      hart_resume_req <= 1'b0;

      if (wr_dmcontrol) begin
        dmactive <= dmi_req_data[0];
        // While inactive only dmactive itself takes the write.
        if (dmactive && dmi_req_data[0]) begin
          hart_halt_req <= dmi_req_data[31];
          ndmreset      <= dmi_req_data[1];
          if (dmi_req_data[30] && !dmi_req_data[31]) begin
            resumeack       <= 1'b0;
            hart_resume_req <= 1'b1;
          end
        end
      end

      if (wr_data0 && !busy)      data0  <= dmi_req_data;
      if (wr_abstractcs && !busy) cmderr <= cmderr & ~dmi_req_data[10:8];
      if (busy_viol && (cmderr == CMDERR_NONE)) cmderr <= CMDERR_BUSY;
      if (err_set)                cmderr <= err_code;
      if (rdata_valid)            data0  <= ar_rdata;
      // Placed after the clear above so a simultaneous ack wins.
      if (hart_resume_ack)        resumeack <= 1'b1;

      // Inactive DM forces its fields to zero, overriding every update above.
      if (!dmactive_nxt) begin
        hart_halt_req   <= 1'b0;
        ndmreset        <= 1'b0;
        hart_resume_req <= 1'b0;
        data0           <= 32'd0;
        cmderr          <= CMDERR_NONE;
        resumeack       <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_dmi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_dmi_responder
// Description : Self-checking bench for dm_dmi_responder. It applies a
//               table of DMI transactions and then hand-written sequences
//               for the abstract command, resume and reset corner cases.
//               The autoexec sequence is compiled only when DM_AUTOEXEC_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_dmi_responder;

  logic        clk;
  logic        rst;
  logic        dmi_req_valid;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_rsp_valid;
  logic [31:0] dmi_rsp_data;
  logic        hart_halt_req;
  logic        hart_resume_req;
  logic        hart_halted;
  logic        hart_resume_ack;
  logic        ndmreset;
  logic        ar_valid;
  logic        ar_write;
  logic [4:0]  ar_regno;
  logic [31:0] ar_wdata;
  logic [31:0] ar_rdata;
  logic        ar_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        halted;
    logic [31:0] exp_rsp;
    logic        exp_halt;
    logic        exp_ndm;
  } vec_t;

  vec_t vecs[$];

  dm_dmi_responder #(
    .DM_VERSION (2),
    .NREGS      (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dmi_req_valid   (dmi_req_valid),
    .dmi_req_addr    (dmi_req_addr),
    .dmi_req_data    (dmi_req_data),
    .dmi_req_op      (dmi_req_op),
    .dmi_rsp_valid   (dmi_rsp_valid),
    .dmi_rsp_data    (dmi_rsp_data),
    .hart_halt_req   (hart_halt_req),
    .hart_resume_req (hart_resume_req),
    .hart_halted     (hart_halted),
    .hart_resume_ack (hart_resume_ack),
    .ndmreset        (ndmreset),
    .ar_valid        (ar_valid),
    .ar_write        (ar_write),
    .ar_regno        (ar_regno),
    .ar_wdata        (ar_wdata),
    .ar_rdata        (ar_rdata),
    .ar_ready        (ar_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // One DMI transaction: request driven for one cycle, response sampled
  // at the following negedge (one cycle after the request edge).
  task automatic dmi(input logic [1:0] op, input logic [6:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    dmi_req_valid = 1'b1;
    dmi_req_op    = op;
    dmi_req_addr  = addr;
    dmi_req_data  = wd;
    @(negedge clk);
    dmi_req_valid = 1'b0;
    dmi_req_op    = 2'b00;
    dmi_req_data  = 32'd0;
    chk("rsp_valid", {31'd0, dmi_rsp_valid}, 32'd1);
    rd = dmi_rsp_data;
  endtask

  task automatic wr(input logic [6:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    dmi(WR, addr, wd, rd);
    chk("wr_rsp_data", rd, 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [6:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    dmi(RD, addr, 32'd0, rd);
    chk(name, rd, exp);
  endtask

  task automatic ar_pulse(input logic [31:0] rdata);
    ar_rdata = rdata;
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    chk("ar_valid_after_ready", {31'd0, ar_valid}, 32'd0);
  endtask

  task automatic add(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                     input logic h, input logic [31:0] er, input logic eh, input logic en);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.halted = h;
    v.exp_rsp = er; v.exp_halt = eh; v.exp_ndm = en;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd0, rd1;

    rst = 1'b1;
    dmi_req_valid = 1'b0; dmi_req_addr = 7'd0; dmi_req_data = 32'd0; dmi_req_op = 2'b00;
    hart_halted = 1'b0; hart_resume_ack = 1'b0; ar_rdata = 32'd0; ar_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {25'd0, dmi_rsp_valid, hart_halt_req, hart_resume_req, ndmreset, ar_valid, ar_write, 1'b0},
        32'd0);
    chk("reset_rsp_data", dmi_rsp_data, 32'd0);
    chk("reset_ar_wdata", ar_wdata, 32'd0);
    rst = 1'b0;

    //   op  addr   wdata         halt  exp_rsp       halt_req ndm
    add(WR, 7'h10, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0);
    add(RD, 7'h11, 32'h0,        1'b0, 32'h00000C82, 1'b0, 1'b0);
    add(RD, 7'h10, 32'h0,        1'b0, 32'h00000001, 1'b0, 1'b0);
    add(RD, 7'h16, 32'h0,        1'b0, 32'h00000001, 1'b0, 1'b0);
    add(WR, 7'h10, 32'h80000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    add(RD, 7'h10, 32'h0,        1'b0, 32'h80000001, 1'b1, 1'b0);
    add(RD, 7'h11, 32'h0,        1'b1, 32'h00000382, 1'b1, 1'b0);
    add(WR, 7'h04, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0);
    add(RD, 7'h04, 32'h0,        1'b1, 32'h12345678, 1'b1, 1'b0);
    add(RD, 7'h17, 32'h0,        1'b1, 32'h00000000, 1'b1, 1'b0);
    add(WR, 7'h7F, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b0);
    add(RD, 7'h7F, 32'h0,        1'b1, 32'h00000000, 1'b1, 1'b0);
    add(RD, 7'h04, 32'h0,        1'b1, 32'h12345678, 1'b1, 1'b0);
    add(2'b00, 7'h04, 32'h0,     1'b1, 32'h00000000, 1'b1, 1'b0);
    add(2'b11, 7'h04, 32'h5,     1'b1, 32'h00000000, 1'b1, 1'b0);
    add(WR, 7'h10, 32'h80000003, 1'b1, 32'h00000000, 1'b1, 1'b1);
    add(RD, 7'h10, 32'h0,        1'b1, 32'h80000003, 1'b1, 1'b1);
    add(RD, 7'h18, 32'h0,        1'b1, 32'h00000000, 1'b1, 1'b1);
    add(WR, 7'h10, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1'b0);
    add(RD, 7'h04, 32'h0,        1'b1, 32'h00000000, 1'b0, 1'b0);
    add(WR, 7'h04, 32'hAAAA5555, 1'b1, 32'h00000000, 1'b0, 1'b0);
    add(RD, 7'h04, 32'h0,        1'b1, 32'h00000000, 1'b0, 1'b0);
    add(WR, 7'h10, 32'h80000003, 1'b1, 32'h00000000, 1'b0, 1'b0);
    add(RD, 7'h10, 32'h0,        1'b1, 32'h00000001, 1'b0, 1'b0);
    add(WR, 7'h10, 32'h80000001, 1'b1, 32'h00000000, 1'b1, 1'b0);
    add(WR, 7'h04, 32'h0BADF00D, 1'b1, 32'h00000000, 1'b1, 1'b0);
    add(RD, 7'h04, 32'h0,        1'b1, 32'h0BADF00D, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      hart_halted = vecs[i].halted;
      dmi(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd0);
      chk($sformatf("vec%0d_rsp", i), rd0, vecs[i].exp_rsp);
      chk($sformatf("vec%0d_halt_req", i), {31'd0, hart_halt_req}, {31'd0, vecs[i].exp_halt});
      chk($sformatf("vec%0d_ndmreset", i), {31'd0, ndmreset}, {31'd0, vecs[i].exp_ndm});
    end

    // Back-to-back reads, each with its own response.
    @(negedge clk);
    dmi_req_valid = 1'b1; dmi_req_op = RD; dmi_req_addr = 7'h10;
    @(negedge clk);
    rd0 = dmi_rsp_data;
    chk("b2b_rsp0_valid", {31'd0, dmi_rsp_valid}, 32'd1);
    dmi_req_addr = 7'h04;
    @(negedge clk);
    dmi_req_valid = 1'b0; dmi_req_op = 2'b00;
    rd1 = dmi_rsp_data;
    chk("b2b_rsp1_valid", {31'd0, dmi_rsp_valid}, 32'd1);
    chk("b2b_rsp0_data", rd0, 32'h80000001);
    chk("b2b_rsp1_data", rd1, 32'h0BADF00D);
    @(negedge clk);
    chk("rsp_valid_one_cycle", {31'd0, dmi_rsp_valid}, 32'd0);

    // GPR write, held off by ar_ready, with busy protection.
    hart_halted = 1'b1;
    wr(7'h04, 32'hDEADBEEF);
    wr(7'h17, 32'h00231005);
    chk("gprw_ar_valid", {31'd0, ar_valid}, 32'd1);
    chk("gprw_ar_write", {31'd0, ar_write}, 32'd1);
    chk("gprw_ar_regno", {27'd0, ar_regno}, 32'd5);
    chk("gprw_ar_wdata", ar_wdata, 32'hDEADBEEF);
    repeat (4) @(negedge clk);
    chk("gprw_ar_valid_held", {31'd0, ar_valid}, 32'd1);
    rd_chk("gprw_busy", 7'h16, 32'h00001001);
    wr(7'h04, 32'h11111111);
    rd_chk("gprw_data0_kept", 7'h04, 32'hDEADBEEF);
    rd_chk("gprw_cmderr_busy", 7'h16, 32'h00001101);
    ar_pulse(32'h0);
    rd_chk("gprw_done", 7'h16, 32'h00000101);
    rd_chk("gprw_data0_after", 7'h04, 32'hDEADBEEF);
    wr(7'h16, 32'h00000100);
    rd_chk("gprw_cmderr_clr", 7'h16, 32'h00000001);

    // GPR read of x3 returns data into data0.
    wr(7'h17, 32'h00221003);
    chk("gprr_ar_valid", {31'd0, ar_valid}, 32'd1);
    chk("gprr_ar_write", {31'd0, ar_write}, 32'd0);
    chk("gprr_ar_regno", {27'd0, ar_regno}, 32'd3);
    ar_pulse(32'hCAFEF00D);
    rd_chk("gprr_data0", 7'h04, 32'hCAFEF00D);
    rd_chk("gprr_idle", 7'h16, 32'h00000001);

    // Unsupported commands and the cmderr!=0 lockout.
    wr(7'h17, 32'h01221005);
    chk("cmdtype_no_ar", {31'd0, ar_valid}, 32'd0);
    rd_chk("cmdtype_err2", 7'h16, 32'h00000201);
    wr(7'h17, 32'h00221003);
    chk("locked_no_ar", {31'd0, ar_valid}, 32'd0);
    rd_chk("locked_err_kept", 7'h16, 32'h00000201);
    wr(7'h16, 32'h00000200);
    wr(7'h17, 32'h00221020);
    chk("regno_hi_no_ar", {31'd0, ar_valid}, 32'd0);
    rd_chk("regno_hi_err2", 7'h16, 32'h00000201);
    wr(7'h16, 32'h00000700);
    wr(7'h17, 32'h00200000);
    chk("notransfer_no_ar", {31'd0, ar_valid}, 32'd0);
    rd_chk("notransfer_ok", 7'h16, 32'h00000001);

    // Transfer while the hart is running.
    hart_halted = 1'b0;
    wr(7'h17, 32'h00221001);
    chk("running_no_ar", {31'd0, ar_valid}, 32'd0);
    rd_chk("running_err4", 7'h16, 32'h00000401);
    wr(7'h16, 32'h00000700);
    rd_chk("running_err_clr", 7'h16, 32'h00000001);

    // Resume request and acknowledgement.
    wr(7'h10, 32'h40000001);
    chk("resume_pulse", {31'd0, hart_resume_req}, 32'd1);
    chk("resume_haltreq", {31'd0, hart_halt_req}, 32'd0);
    @(negedge clk);
    chk("resume_pulse_end", {31'd0, hart_resume_req}, 32'd0);
    rd_chk("resume_noack", 7'h11, 32'h00000C82);
    hart_resume_ack = 1'b1;
    @(negedge clk);
    hart_resume_ack = 1'b0;
    rd_chk("resume_ack", 7'h11, 32'h00030C82);

`ifdef DM_AUTOEXEC_EN
    hart_halted = 1'b1;
    wr(7'h17, 32'h00221003);
    chk("auto_first_ar", {31'd0, ar_valid}, 32'd1);
    ar_pulse(32'h00000011);
    wr(7'h18, 32'h00000001);
    rd_chk("auto_reg", 7'h18, 32'h00000001);
    ar_rdata = 32'h33333333;
    rd_chk("auto_read_old", 7'h04, 32'h00000011);
    chk("auto_ar_valid", {31'd0, ar_valid}, 32'd1);
    chk("auto_ar_regno", {27'd0, ar_regno}, 32'd3);
    ar_pulse(32'h33333333);
    wr(7'h18, 32'h00000000);
    rd_chk("auto_data0", 7'h04, 32'h33333333);
`endif

    // Reset in the middle of a transfer.
    hart_halted = 1'b1;
    wr(7'h17, 32'h00221002);
    chk("rst_ar_before", {31'd0, ar_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ar_dropped", {31'd0, ar_valid}, 32'd0);
    rd_chk("rst_dmcontrol", 7'h10, 32'h00000000);
    rd_chk("rst_abstractcs", 7'h16, 32'h00000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
